dropout_mask_ctrl: RTL and testbench
====================================

Name: dropout_mask_ctrl

Overview:
Sequencing controller for the dropout datapath. It runs one "layer pass" of a programmed number of N-lane activation vectors. Per lane it generates pseudo-random values with hardware LFSRs and compares them against a programmable threshold to build a drop mask. It applies the mask to each vector and streams the result downstream over a valid/ready handshake. It sits between the neuron-vector producer and the next layer, and replaces simulation-only random sources with synthesizable, seed-reproducible ones.

Parameters:
N, 8, number of lanes (neurons) per vector
DW, 8, data width per lane
RW, 16, LFSR/threshold width (fixed at 16 for the chosen polynomial)
CNT_W, 16, width of vector counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  pulse; begins a pass when idle
train_mode  in  1  1 = dropout active, 0 = inference (pass-through)
cfg_seed  in  32  LFSR seed, latched on start
cfg_threshold  in  RW  drop threshold, latched on start
cfg_count  in  CNT_W  vectors in this pass, latched on start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of pass
s_valid  in  1  input vector valid
s_ready  out  1  input vector accept
s_data  in  N*DW  input vector, lane i = bits [i*DW +: DW]
m_valid  out  1  output vector valid
m_ready  in  1  downstream accept
m_data  out  N*DW  masked vector
m_mask  out  N  1 = lane i dropped in m_data
vec_idx  out  CNT_W  index of the vector currently in m_data

Behaviour:
- Reset: state IDLE; busy, done, s_ready, m_valid = 0; m_data, m_mask, vec_idx = 0; all LFSRs = 0; latched cfg = 0.
- States: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE: s_ready=0. start=1 -> latch cfg_*, train_mode -> SEED. start is ignored in any other state.
- SEED (1 cycle): lane i LFSR loaded with cfg_seed[15:0] ^ (16'h9E37*i mod 2^16). If the result is 0, load 16'hACE1 instead. If cfg_count==0 -> DONE, else -> RUN.
- LFSR step: Fibonacci, next = {l[14:0], l[15]^l[13]^l[12]^l[10]}. Maximal length 65535; never 0 after SEED.
- RUN: s_ready = !m_valid || m_ready (single output register, full throughput).
- On s_valid && s_ready, the output register loads:
  - m_mask[i] = train_mode && (lfsr_i <= threshold), using the current LFSR value.
  - m_data lane i = m_mask[i] ? 0 : s_data lane i.
  - vec_idx = accepted count before increment.
  - m_valid = 1.
  - All LFSRs step once, in both modes, so the random sequence depends only on seed and vector number.
- LFSRs hold when no input handshake occurs.
- Threshold semantics: 0 never drops; 16'hFFFF always drops. Drop probability = threshold/65535.
- m_valid clears on m_ready when no new input is accepted in the same cycle. Simultaneous accept and output handshake reloads the register with m_valid staying 1.
- When the accepted count reaches the latched count: s_ready=0 from the next cycle -> DRAIN.
- DRAIN: wait until m_valid==0 (last vector consumed) -> DONE.
- DONE (1 cycle): done=1 -> IDLE. LFSR state is retained but reseeded by the next start.
- m_data, m_mask and vec_idx hold while m_valid && !m_ready.
- Counter compare uses CNT_W width; cfg_count up to 2^CNT_W-1 is supported; no wrap within a pass.
- Reset mid-pass: immediate return to reset values; any in-flight vector is discarded and no done pulse is generated.

Decomposition:
- Package dropout_pkg:
  - state enum
  - LFSR tap constants
  - lane seed constant 16'h9E37
  - zero-seed fallback 16'hACE1
  - RW=16 localparam
- Sub-module dropout_lfsr16: ports clk, reset, load, load_val, step, value. It is instantiated N times via generate.

Test Plan:
- N=8, DW=8, seed 32'h1, threshold 0, train 1, count 4, lane data 8'h11..8'h88, m_ready=1 -> all data passes, m_mask=0, vec_idx 0..3, done pulses one cycle after last output consumed.
- threshold 16'hFFFF, train 1, count 3 -> m_data=0 and m_mask=8'hFF for all 3 vectors.
- Seed 32'h0000_ACE1, threshold 16'h8000, count 1000: drop fraction per lane is within 0.45-0.55; the same seed rerun gives a bit-identical mask sequence; a model of the LFSR plus compare matches every mask.
- Same seed, train 0 -> masks all 0 and data unchanged. A following train-1 pass with the same seed gives masks identical to a train-1-only run.
- m_ready toggled with pattern 1,0,0,1 and s_valid gapped -> no vector lost or duplicated; m_data is stable while stalled; LFSR steps only on input accept.
- cfg_count=0 -> done pulse 2 cycles after start with no s_ready; reset asserted mid-pass at vector 2 -> m_valid=0, busy=0 immediately, no done pulse.

Source files
------------

// File: rtl/dropout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dropout_pkg
// Brief    : Shared types and constants for the dropout mask controller.
// Revision : 1.0 - initial release
// ============================================================================
package dropout_pkg;

    localparam int c_RW = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam int c_TAP_A = 15;
    localparam int c_TAP_B = 13;
    localparam int c_TAP_C = 12;
    localparam int c_TAP_D = 10;

    localparam logic [c_RW-1:0] c_LANE_SEED = 16'h9E37;
    localparam logic [c_RW-1:0] c_ZERO_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // An all-zero LFSR would lock up, so a zero lane seed is substituted.
    function automatic logic [c_RW-1:0] lane_seed(input logic [c_RW-1:0] seed,
                                                  input int          lane);
        logic [c_RW-1:0] w_val;
        w_val = seed ^ 16'(32'(c_LANE_SEED) * 32'(lane));
        return (w_val == '0) ? c_ZERO_SEED : w_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dropout_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : dropout_lfsr16
// Brief    : 16-bit Fibonacci LFSR with synchronous load and step enable.
// Revision : 1.0 - initial release
// ============================================================================
module dropout_lfsr16
    import dropout_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [c_RW-1:0] load_val,
    input  logic            step,
    output logic [c_RW-1:0] value
);

    logic [c_RW-1:0] r_lfsr;
    logic            w_fb;

    assign w_fb = r_lfsr[c_TAP_A] ^ r_lfsr[c_TAP_B] ^ r_lfsr[c_TAP_C] ^ r_lfsr[c_TAP_D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= '0;
        end else if (load) begin
            r_lfsr <= load_val;
        end else if (step) begin
            r_lfsr <= {r_lfsr[c_RW-2:0], w_fb};
        end
    end

    assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/dropout_mask_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dropout_mask_ctrl
// Brief    : Layer-pass sequencer applying per-lane LFSR dropout masks.
// Revision : 1.0 - initial release
// ============================================================================
module dropout_mask_ctrl
    import dropout_pkg::*;
#(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int RW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             train_mode,
    input  logic [31:0]      cfg_seed,
    input  logic [RW-1:0]    cfg_threshold,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N*DW-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N*DW-1:0]  m_data,
    output logic [N-1:0]     m_mask,
    output logic [CNT_W-1:0] vec_idx
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_train;
    logic [RW-1:0]    r_thresh;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_acc;
    logic [c_RW-1:0]  r_seed;

    logic             w_accept;
    logic             w_last;
    logic             w_seed_load;
    logic [c_RW-1:0]  w_lfsr [N];
    logic [N-1:0]     w_mask;
    logic [N*DW-1:0]  w_data;
    logic             w_unused_seed_hi;

    // Only the low half of the seed feeds the 16-bit lanes.
    assign w_unused_seed_hi = ^cfg_seed[31:16];

    assign w_seed_load = (r_state == ST_SEED);
    assign w_accept    = s_valid && s_ready;
    assign w_last      = ((r_acc + CNT_W'(1)) == r_count);

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            logic [c_RW-1:0] w_lane_seed;

            assign w_lane_seed = lane_seed(r_seed, i);

            dropout_lfsr16 u_lfsr (
                .clk      (clk),
                .reset    (reset),
                .load     (w_seed_load),
                .load_val (w_lane_seed),
                .step     (w_accept),
                .value    (w_lfsr[i])
            );

            assign w_mask[i]            = r_train && (w_lfsr[i] <= r_thresh);
            assign w_data[i*DW +: DW]   = w_mask[i] ? '0 : s_data[i*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        done        = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEED;
                end
            end
            ST_SEED: begin
                w_state_nxt = (r_count == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                s_ready = !m_valid || m_ready;
                if (s_valid && s_ready && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!m_valid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_train  <= 1'b0;
            r_thresh <= '0;
            r_count  <= '0;
            r_seed   <= '0;
            r_acc    <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_mask   <= '0;
            vec_idx  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_train  <= train_mode;
                r_thresh <= cfg_threshold;
                r_count  <= cfg_count;
                r_seed   <= cfg_seed[c_RW-1:0];
                r_acc    <= '0;
            end
            // Output register holds its contents until a new vector is accepted.
            if (w_accept) begin
                m_valid <= 1'b1;
                m_data  <= w_data;
                m_mask  <= w_mask;
                vec_idx <= r_acc;
                r_acc   <= r_acc + CNT_W'(1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dropout_mask_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dropout_mask_ctrl
// Brief    : Randomized self-checking bench with a behavioural dropout model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dropout_mask_ctrl;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int RW    = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             train_mode = 1'b0;
    logic [31:0]      cfg_seed = '0;
    logic [RW-1:0]    cfg_threshold = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             busy, done;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [N*DW-1:0]  s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [N*DW-1:0]  m_data;
    logic [N-1:0]     m_mask;
    logic [CNT_W-1:0] vec_idx;

    always #5 clk = ~clk;

    dropout_mask_ctrl #(.N(N), .DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .train_mode(train_mode),
        .cfg_seed(cfg_seed), .cfg_threshold(cfg_threshold), .cfg_count(cfg_count),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mask(m_mask),
        .vec_idx(vec_idx)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] model_seed(input logic [15:0] s, input int lane);
        logic [31:0] p;
        logic [15:0] v;
        p = 32'h9E37 * lane;
        v = s ^ p[15:0];
        return (v == 16'h0) ? 16'hACE1 : v;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [7:0]  mask;
        logic [15:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mdl_lfsr [8];
    logic [15:0] mdl_thr;
    logic        mdl_train;
    logic [15:0] mdl_vidx;
    logic [7:0]  mask_log[$];
    logic [7:0]  ref_log[$];
    int          drop_cnt [8];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_mask;
    logic [15:0] prev_idx;

    // Reference model plus per-cycle output comparison.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (start) begin
                for (int i = 0; i < 8; i++) begin
                    mdl_lfsr[i] = model_seed(cfg_seed[15:0], i);
                    drop_cnt[i] = 0;
                end
                mdl_thr   = cfg_threshold;
                mdl_train = train_mode;
                mdl_vidx  = '0;
                mask_log.delete();
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {63'd0, m_valid}, 64'd0);
                end else begin
                    chk("out_data", m_data, exp_q[0].data);
                    chk("out_mask", {56'd0, m_mask}, {56'd0, exp_q[0].mask});
                    chk("out_idx", {48'd0, vec_idx}, {48'd0, exp_q[0].idx});
                end
                if (prev_stall) begin
                    chk("stall_data_stable", m_data, prev_data);
                    chk("stall_idx_stable", {48'd0, vec_idx}, {48'd0, prev_idx});
                    chk("stall_mask_stable", {56'd0, m_mask}, {56'd0, prev_mask});
                end
            end else begin
                chk("no_pending_output", 64'(exp_q.size()), 64'd0);
            end
            if (m_valid && m_ready) begin
                mask_log.push_back(m_mask);
                for (int i = 0; i < 8; i++) drop_cnt[i] += int'(m_mask[i]);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                exp_t e;
                for (int i = 0; i < 8; i++) begin
                    e.mask[i]         = mdl_train && (mdl_lfsr[i] <= mdl_thr);
                    e.data[i*8 +: 8]  = e.mask[i] ? 8'h00 : s_data[i*8 +: 8];
                    mdl_lfsr[i]       = lfsr_next(mdl_lfsr[i]);
                end
                e.idx    = mdl_vidx;
                mdl_vidx = mdl_vidx + 16'd1;
                exp_q.push_back(e);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_mask  = m_mask;
            prev_idx   = vec_idx;
        end
    end

    task automatic start_pass(input logic [31:0] seed, input logic [15:0] thr,
                              input int cnt, input logic train);
        start         = 1'b1;
        cfg_seed      = seed;
        cfg_threshold = thr;
        cfg_count     = 16'(cnt);
        train_mode    = train;
        @(posedge clk); #1;
        start      = 1'b0;
        train_mode = ~train;
        cfg_seed   = ~seed;
    endtask

    // vmode: 0 back-to-back, 1 gapped; rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    // lit: 1 expect pass-through of the fixed pattern, 2 expect full drop
    task automatic run_pass(input logic [31:0] seed, input logic [15:0] thr, input int cnt,
                            input logic train, input int vmode, input int rmode,
                            input int dmode, input int lit);
        logic [63:0] pat;
        int sent, got, done_cnt, cyc, post, limit;
        logic pend;
        pat = 64'h8877665544332211;
        sent = 0; got = 0; done_cnt = 0; cyc = 0; post = 0; pend = 1'b0;
        limit = cnt * 8 + 50;
        start_pass(seed, thr, cnt, train);
        while (cyc < limit && post < 3) begin
            if (!pend && sent < cnt && (vmode == 0 || $urandom_range(1, 0) == 1)) begin
                pend   = 1'b1;
                s_data = (dmode == 0) ? pat : {$urandom, $urandom};
            end
            s_valid = pend;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready = 1'($urandom_range(1, 0));
            endcase
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (lit == 1) begin
                    chk("lit_pass_mask", {56'd0, m_mask}, 64'd0);
                    chk("lit_pass_data", m_data, pat);
                    chk("lit_pass_idx", {48'd0, vec_idx}, 64'(got));
                end else if (lit == 2) begin
                    chk("lit_drop_mask", {56'd0, m_mask}, 64'hFF);
                    chk("lit_drop_data", m_data, 64'd0);
                end
                got++;
            end
            if (s_valid && s_ready) begin
                sent++;
                pend = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_drain", 64'(got), 64'(cnt));
            end
            if (done_cnt > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("pass_sent", 64'(sent), 64'(cnt));
        chk("pass_got", 64'(got), 64'(cnt));
        chk("pass_done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int nz, guard, sent;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_mask", {56'd0, m_mask}, 64'd0);
        chk("rst_vec_idx", {48'd0, vec_idx}, 64'd0);
        @(posedge clk); #1;

        chk("model_zero_fallback", {48'd0, model_seed(16'h9E37, 1)}, 64'hACE1);
        chk("model_lane2_seed", {48'd0, model_seed(16'h0001, 2)}, 64'h3C6F);
        chk("model_lfsr_step", {48'd0, lfsr_next(16'hACE1)}, 64'h59C3);

        run_pass(32'h0000_0001, 16'h0000, 4, 1'b1, 0, 0, 0, 1);
        run_pass(32'h1234_5678, 16'hFFFF, 3, 1'b1, 0, 0, 0, 2);

        run_pass(32'h0000_ACE1, 16'h8000, 1000, 1'b1, 1, 2, 1, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (drop_cnt[i] < 450 || drop_cnt[i] > 550) begin
                errors++;
                $display("FAIL drop_fraction lane %0d: got %0d of 1000, expected 450..550", i, drop_cnt[i]);
            end
        end
        ref_log = mask_log;

        run_pass(32'h0000_ACE1, 16'h8000, 1000, 1'b1, 0, 0, 1, 0);
        chk("rerun_len", 64'(mask_log.size()), 64'(ref_log.size()));
        for (int i = 0; i < mask_log.size() && i < ref_log.size(); i++)
            chk("rerun_mask", {56'd0, mask_log[i]}, {56'd0, ref_log[i]});

        run_pass(32'h0000_ACE1, 16'h8000, 1000, 1'b0, 1, 2, 1, 0);
        nz = 0;
        foreach (mask_log[i]) if (mask_log[i] != 8'h00) nz++;
        chk("train0_masks_zero", 64'(nz), 64'd0);

        run_pass(32'h0000_ACE1, 16'h8000, 1000, 1'b1, 1, 1, 1, 0);
        chk("after_infer_len", 64'(mask_log.size()), 64'(ref_log.size()));
        for (int i = 0; i < mask_log.size() && i < ref_log.size(); i++)
            chk("after_infer_mask", {56'd0, mask_log[i]}, {56'd0, ref_log[i]});

        run_pass(32'hDEAD_BEEF, 16'h6000, 12, 1'b1, 1, 1, 1, 0);

        start_pass(32'h0000_0042, 16'h4000, 0, 1'b1);
        @(negedge clk);
        chk("cnt0_seed_busy", {63'd0, busy}, 64'd1);
        chk("cnt0_seed_done", {63'd0, done}, 64'd0);
        chk("cnt0_seed_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        chk("cnt0_done", {63'd0, done}, 64'd1);
        chk("cnt0_done_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        chk("cnt0_done_clear", {63'd0, done}, 64'd0);
        chk("cnt0_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        start_pass(32'h5555_1234, 16'h8000, 6, 1'b1);
        s_valid = 1'b1; m_ready = 1'b1; s_data = {$urandom, $urandom};
        sent = 0; guard = 0;
        while (sent < 3 && guard < 50) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            s_data = {$urandom, $urandom};
            guard++;
        end
        chk("midpass_accepts", 64'(sent), 64'd3);
        chk("midpass_vec_idx", {48'd0, vec_idx}, 64'd2);
        s_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("midrst_vec_idx", {48'd0, vec_idx}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_done", {63'd0, done}, 64'd0);
            chk("midrst_stay_idle", {63'd0, busy}, 64'd0);
        end
        @(posedge clk); #1;

        run_pass(32'h0000_9E37, 16'h7000, 5, 1'b1, 1, 2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
